// File: rtl/instr_encode_loader_if.sv
// Request and IMEM-write signal bundle for instr_encode_loader.
// master = request/IMEM-side driver, slave = the loader itself.
interface instr_encode_loader_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [2:0]        req_kind;
    logic [4:0]        req_rs;
    logic [4:0]        req_rt;
    logic [4:0]        req_rd;
    logic [5:0]        req_funct;
    logic [25:0]       req_imm;
    logic              imem_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              bad_req;
    logic [ADDR_W:0]   wr_count;

    modport master (
        output req_valid, req_kind, req_rs, req_rt, req_rd, req_funct, req_imm, imem_ready,
        input  req_ready, imem_we, imem_addr, imem_wdata, bad_req, wr_count
    );

    modport slave (
        input  req_valid, req_kind, req_rs, req_rt, req_rd, req_funct, req_imm, imem_ready,
        output req_ready, imem_we, imem_addr, imem_wdata, bad_req, wr_count
    );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes field-level requests into MIPS words, buffers them and streams them into IMEM.
// Define INSTR_ENC_FUNCT_CHECK_EN to reject R-type requests with an unsupported funct.
module instr_encode_loader #(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned ADDR_W     = 10,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    instr_encode_loader_if.slave bus
);
    localparam int unsigned       PTR_W    = $clog2(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [PTR_W:0]    FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        K_RTYPE = 3'd0,
        K_ORI   = 3'd1,
        K_ADDIU = 3'd2,
        K_LW    = 3'd3,
        K_SW    = 3'd4,
        K_BEQ   = 3'd5,
        K_J     = 3'd6,
        K_RSVD  = 3'd7
    } req_kind_e;

    logic [31:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    count;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   wcnt_q;
    logic              bad_q;

    logic        fifo_full, fifo_empty;
    logic        accept, push, pop, reject;
    logic [31:0] enc;

    always_comb begin
        enc    = '0;
        reject = 1'b0;
        case (req_kind_e'(bus.req_kind))
            K_RTYPE: begin
                enc = {6'b000000, bus.req_rs, bus.req_rt, bus.req_rd, 5'b00000, bus.req_funct};
`ifdef INSTR_ENC_FUNCT_CHECK_EN
                reject = !(bus.req_funct inside {6'h20, 6'h21, 6'h22, 6'h23,
                                                 6'h24, 6'h25, 6'h2A, 6'h2B});
`endif
            end
            K_ORI:   enc = {6'b001101, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
            K_ADDIU: enc = {6'b001001, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
            K_LW:    enc = {6'b100011, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
            K_SW:    enc = {6'b101011, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
            K_BEQ:   enc = {6'b000100, bus.req_rs, bus.req_rt, bus.req_imm[15:0]};
            K_J:     enc = {6'b000010, bus.req_imm};
            default: reject = 1'b1;
        endcase
    end

    // Readiness looks only at occupancy, so a pop cannot make room for a push in the same cycle.
    assign fifo_full  = (count == FULL_CNT);
    assign fifo_empty = (count == '0);
    assign accept     = bus.req_valid && bus.req_ready;
    assign push       = accept && !reject;
    assign pop        = bus.imem_we;

    assign bus.req_ready  = !fifo_full && !clear && !rst;
    assign bus.imem_we    = !fifo_empty && bus.imem_ready && !clear && !rst;
    assign bus.imem_wdata = fifo_empty ? 32'h0 : mem[rd_ptr];
    assign bus.imem_addr  = addr_q;
    assign bus.bad_req    = bad_q;
    assign bus.wr_count   = wcnt_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= enc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            addr_q <= BASE;
            wcnt_q <= '0;
            bad_q  <= 1'b0;
        end else begin
            bad_q <= accept && reject;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                addr_q <= addr_q + 1'b1;
                if (wcnt_q != '1) begin
                    wcnt_q <= wcnt_q + 1'b1;
                end
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule
